// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for a 5-stage pipeline: tracks EX/MEM/WB destinations,
// raises hazard_stall for RAW dependencies and counts stall cycles.
module hazard_scoreboard #(
  parameter  int CNT_W          = 16,
  // Register-file index width, mirrored from settings.h (4 -> 16 registers).
  localparam int REG_FILE_DEPTH = 4,
  localparam int NUM_REGS       = 1 << REG_FILE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      forward_en,
  input  logic                      id_valid,
  input  logic [REG_FILE_DEPTH-1:0] id_src1,
  input  logic [REG_FILE_DEPTH-1:0] id_src2,
  input  logic                      id_two_src,
  input  logic                      id_wb_en,
  input  logic [REG_FILE_DEPTH-1:0] id_dest,
  input  logic                      id_mem_read,
  input  logic                      flush,
  input  logic                      mem_ready,
  output logic                      hazard_stall,
  output logic                      freeze,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic [CNT_W-1:0]          stall_count
);

  typedef struct packed {
    logic                      valid;
    logic [REG_FILE_DEPTH-1:0] dest;
    logic                      is_load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ex_d;
  logic  match_ex, match_mem;
  logic [NUM_REGS-1:0] mask_d;

  assign freeze = ~mem_ready;

  // WB is never compared: the register file writes it on the falling edge.
  always_comb begin
    match_ex  = ex_q.valid  && ((id_src1 == ex_q.dest)  || (id_two_src && (id_src2 == ex_q.dest)));
    match_mem = mem_q.valid && ((id_src1 == mem_q.dest) || (id_two_src && (id_src2 == mem_q.dest)));
    hazard_stall = 1'b0;
    if (id_valid && !flush)
      hazard_stall = forward_en ? (match_ex && ex_q.is_load) : (match_ex || match_mem);
  end

  always_comb begin
    ex_d = '0;
    if (!hazard_stall && !flush) begin
      ex_d.valid   = id_valid && id_wb_en;
      ex_d.dest    = id_dest;
      ex_d.is_load = id_mem_read;
    end
  end

  // Mask is built from the post-advance slots so it lands one cycle after the change.
  always_comb begin
    mask_d = '0;
    if (ex_d.valid)  mask_d[ex_d.dest]  = 1'b1;
    if (ex_q.valid)  mask_d[ex_q.dest]  = 1'b1;
    if (mem_q.valid) mask_d[mem_q.dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      pending_mask <= '0;
      stall_count  <= '0;
    end else if (mem_ready) begin
      ex_q         <= ex_d;
      mem_q        <= ex_q;
      wb_q         <= mem_q;
      pending_mask <= mask_d;
      if (hazard_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, no-forward RAW, flush,
// freeze, counter saturation and mid-stall reset.
module tb_hazard_scoreboard;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst, forward_en, id_valid, id_two_src, id_wb_en, id_mem_read;
  logic        flush, mem_ready;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        hazard_stall, freeze;
  logic [15:0] pending_mask;
  logic [CNT_W-1:0] stall_count;

  int n_vec = 0;
  int n_bad = 0;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
    .flush(flush), .mem_ready(mem_ready), .hazard_stall(hazard_stall),
    .freeze(freeze), .pending_mask(pending_mask), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic [3:0] dest,
                       input logic ld, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two);
    id_valid = v; id_wb_en = wb; id_dest = dest; id_mem_read = ld;
    id_src1 = s1; id_src2 = s2; id_two_src = two;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1'b1; forward_en = 1'b1; flush = 1'b0; mem_ready = 1'b1;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    #2;
    chk("rst_mask", 32'(pending_mask), 32'h0);
    chk("rst_count", 32'(stall_count), 32'd0);
    chk("rst_stall", 32'(hazard_stall), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);

    // Load-use with forwarding: one bubble.
    drive(1, 1, 4'd3, 1, 4'd0, 4'd0, 0);  #2;
    chk("lu_ldr_stall", 32'(hazard_stall), 32'd0);
    cyc();
    chk("lu_ldr_mask", 32'(pending_mask), 32'h0008);
    drive(1, 1, 4'd4, 0, 4'd3, 4'd0, 0);  #2;
    chk("lu_stall1", 32'(hazard_stall), 32'd1);
    cyc();
    chk("lu_count", 32'(stall_count), 32'd1);
    chk("lu_mask_bub", 32'(pending_mask), 32'h0008);
    #2;
    chk("lu_stall2", 32'(hazard_stall), 32'd0);
    cyc();
    chk("lu_add_mask", 32'(pending_mask), 32'h0018);
    drain();
    chk("lu_drain", 32'(pending_mask), 32'h0);

    // No forwarding: dependency on src2 stalls two cycles.
    forward_en = 1'b0;
    drive(1, 1, 4'd5, 0, 4'd0, 4'd0, 0);  cyc();
    drive(1, 1, 4'd6, 0, 4'd1, 4'd5, 1);  #2;
    chk("nf_stall_a", 32'(hazard_stall), 32'd1);
    cyc();
    chk("nf_count_a", 32'(stall_count), 32'd2);
    chk("nf_stall_b", 32'(hazard_stall), 32'd1);
    cyc();
    chk("nf_count_b", 32'(stall_count), 32'd3);
    chk("nf_stall_c", 32'(hazard_stall), 32'd0);
    cyc();
    chk("nf_sub_mask", 32'(pending_mask), 32'h0040);
    drain();
    drive(1, 1, 4'd5, 0, 4'd0, 4'd0, 0);  cyc();
    drive(1, 1, 4'd6, 0, 4'd1, 4'd5, 0);  #2;
    chk("nf_one_src", 32'(hazard_stall), 32'd0);
    cyc();
    chk("nf_one_cnt", 32'(stall_count), 32'd3);
    drain();
    // Non-writing instruction occupies EX as an invalid entry.
    drive(1, 0, 4'd9, 0, 4'd0, 4'd0, 0);  cyc();
    chk("nowb_mask", 32'(pending_mask), 32'h0);
    drive(1, 1, 4'd7, 0, 4'd9, 4'd0, 0);  #2;
    chk("nowb_stall", 32'(hazard_stall), 32'd0);
    cyc();
    drain();

    // Flush kills the dependent instruction; the load still advances.
    forward_en = 1'b1;
    drive(1, 1, 4'd2, 1, 4'd0, 4'd0, 0);  cyc();
    drive(1, 1, 4'd7, 0, 4'd2, 4'd0, 0);  flush = 1'b1;  #2;
    chk("fl_stall", 32'(hazard_stall), 32'd0);
    cyc();
    flush = 1'b0;
    chk("fl_mask", 32'(pending_mask), 32'h0004);
    chk("fl_count", 32'(stall_count), 32'd3);
    drain();

    // Freeze during a load-use stall; flush is ignored while frozen.
    drive(1, 1, 4'd3, 1, 4'd0, 4'd0, 0);  cyc();
    drive(1, 1, 4'd4, 0, 4'd3, 4'd0, 0);  mem_ready = 1'b0;  #2;
    chk("fz_freeze", 32'(freeze), 32'd1);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      cyc();
      chk("fz_mask", 32'(pending_mask), 32'h0008);
      chk("fz_count", 32'(stall_count), 32'd3);
    end
    flush = 1'b0; mem_ready = 1'b1;  #2;
    chk("fz_resume_stall", 32'(hazard_stall), 32'd1);
    chk("fz_resume_freeze", 32'(freeze), 32'd0);
    cyc();
    chk("fz_resume_cnt", 32'(stall_count), 32'd4);
    chk("fz_resume_mask", 32'(pending_mask), 32'h0008);
    #2;
    chk("fz_proceed", 32'(hazard_stall), 32'd0);
    cyc();
    chk("fz_add_mask", 32'(pending_mask), 32'h0018);
    drain();

    // Saturation: 10 stalls reach 14, further stalls hold at 15.
    for (int i = 0; i < 13; i++) begin
      drive(1, 1, 4'd1, 1, 4'd0, 4'd0, 0);  cyc();
      drive(1, 1, 4'd4, 0, 4'd1, 4'd0, 0);  cyc();
      if (i == 9)  chk("sat_pre", 32'(stall_count), 32'd14);
      if (i == 10) chk("sat_max", 32'(stall_count), 32'd15);
      if (i == 12) chk("sat_hold", 32'(stall_count), 32'd15);
    end
    drain();

    // Reset mid-stall with three valid slots; reset beats freeze and flush.
    forward_en = 1'b0;
    drive(1, 1, 4'd1, 0, 4'd8, 4'd9, 0);  cyc();
    drive(1, 1, 4'd2, 0, 4'd8, 4'd9, 0);  cyc();
    drive(1, 1, 4'd3, 0, 4'd8, 4'd9, 0);  cyc();
    chk("rs_full_mask", 32'(pending_mask), 32'h000E);
    drive(1, 1, 4'd5, 0, 4'd3, 4'd9, 0);  #2;
    chk("rs_pre_stall", 32'(hazard_stall), 32'd1);
    rst = 1'b1; mem_ready = 1'b0; flush = 1'b1;
    cyc();
    rst = 1'b0; mem_ready = 1'b1; flush = 1'b0;  #2;
    chk("rs_mask", 32'(pending_mask), 32'h0);
    chk("rs_count", 32'(stall_count), 32'd0);
    chk("rs_stall", 32'(hazard_stall), 32'd0);
    cyc();
    chk("rs_issue_mask", 32'(pending_mask), 32'h0020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
